band_peak_meter: RTL

//  Per-band peak-hold/decay level meter downstream of adc_converter; consumes (freq_label, amplitude) samples.

---
 rtl/band_peak_meter_if.sv | 29 ++
 rtl/band_peak_meter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/band_peak_meter_if.sv
// band_peak_meter_if
//   Sample stream from adc_converter into band_peak_meter.
//   sample_valid  source -> sink  sample present
//   sample_ready  sink -> source  sink accepts sample this cycle
//   freq_label    source -> sink  0=low 1=mid 2=high 3=none
//   amp_in        source -> sink  sample amplitude (AMP_W bits)
//   modports: master (sample source), slave (band_peak_meter)
interface band_peak_meter_if #(
    parameter int AMP_W = 4
);
    logic             sample_valid;
    logic             sample_ready;
    logic [1:0]       freq_label;
    logic [AMP_W-1:0] amp_in;

    modport master (
        output sample_valid,
        output freq_label,
        output amp_in,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  freq_label,
        input  amp_in,
        output sample_ready
    );
endinterface

// File: rtl/band_peak_meter.sv
// band_peak_meter
//   Per-band (low/mid/high) peak-hold / linear-decay level meter with a
//   registered 16-LED bar for one selected band.
//   Build option: define PEAK_METER_DOT_EN for dot-mode bar (only bit L-1
//   set); undefined gives thermometer bar (bits [L-1:0] set). Bit 15 is
//   always the overload flag.
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   enable    in   run meter; low returns to IDLE (levels frozen)
//   clear     in   pulse: zero all bands via a 3-cycle sweep
//   band_sel  in   band shown on led_bar (3 => blank bar)
//   smp       slave modport of band_peak_meter_if (sample handshake)
//   low_lvl / mid_lvl / high_lvl  out  level registers
//   overload  out  selected band level at full scale (registered)
//   led_bar   out  registered bar for band_sel
module band_peak_meter #(
    parameter int HOLD_CYCLES  = 8,
    parameter int DECAY_CYCLES = 4,
    parameter int AMP_W        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [1:0]            band_sel,
    band_peak_meter_if.slave      smp,
    output logic [AMP_W-1:0]      low_lvl,
    output logic [AMP_W-1:0]      mid_lvl,
    output logic [AMP_W-1:0]      high_lvl,
    output logic                  overload,
    output logic [(2**AMP_W)-1:0] led_bar
);
    localparam int NUM_LEDS = 2 ** AMP_W;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int DW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]       state;
    logic [1:0]       clr_idx;
    logic [AMP_W-1:0] level [3];
    logic [HW-1:0]    hold  [3];
    logic [DW-1:0]    decay [3];

    logic                ready;
    logic                xfer;
    logic [AMP_W-1:0]    sel_lvl;
    logic                sel_ovl;
    logic [31:0]         sel_lvl_w;
    logic [NUM_LEDS-1:0] bar_next;

    assign ready            = (state == S_RUN) && !clear;
    assign smp.sample_ready = ready;
    assign xfer             = smp.sample_valid && ready;

    assign low_lvl  = level[0];
    assign mid_lvl  = level[1];
    assign high_lvl = level[2];

    always_comb begin
        sel_lvl = '0;
        case (band_sel)
            2'd0:    sel_lvl = level[0];
            2'd1:    sel_lvl = level[1];
            2'd2:    sel_lvl = level[2];
            default: sel_lvl = '0;
        endcase
    end

    // band_sel==3 forces level 0, so the blank bar falls out naturally.
    assign sel_ovl   = (band_sel != 2'd3) && (sel_lvl == '1);
    assign sel_lvl_w = 32'(sel_lvl);

    always_comb begin
        bar_next = '0;
        for (int unsigned i = 0; i < NUM_LEDS - 1; i++) begin
`ifdef PEAK_METER_DOT_EN
            bar_next[i] = (sel_lvl_w == i + 1);
`else
            bar_next[i] = (i < sel_lvl_w);
`endif
        end
        bar_next[NUM_LEDS-1] = sel_ovl;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            clr_idx  <= '0;
            led_bar  <= '0;
            overload <= 1'b0;
            for (int unsigned b = 0; b < 3; b++) begin
                level[b] <= '0;
                hold[b]  <= '0;
                decay[b] <= '0;
            end
        end else begin
            led_bar  <= bar_next;
            overload <= sel_ovl;

            case (state)
                S_IDLE: begin
                    if (enable) state <= S_RUN;
                end
                S_RUN: begin
                    if (clear) begin
                        state   <= S_CLEAR;
                        clr_idx <= '0;
                    end else if (!enable) begin
                        state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    if (clr_idx == 2'd2) begin
                        clr_idx <= '0;
                        state   <= enable ? S_RUN : S_IDLE;
                    end else begin
                        clr_idx <= clr_idx + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            for (int unsigned b = 0; b < 3; b++) begin
                if (state == S_CLEAR) begin
                    // One band per sweep cycle; the others stay frozen.
                    if (clr_idx == b[1:0]) begin
                        level[b] <= '0;
                        hold[b]  <= '0;
                        decay[b] <= '0;
                    end
                end else if (state == S_RUN) begin
                    // Peak update has priority over the decay step.
                    if (xfer && smp.freq_label == b[1:0] && smp.amp_in >= level[b]) begin
                        level[b] <= smp.amp_in;
                        hold[b]  <= HW'(HOLD_CYCLES);
                        decay[b] <= '0;
                    end else if (level[b] == '0) begin
                        hold[b]  <= '0;
                        decay[b] <= '0;
                    end else if (hold[b] != '0) begin
                        hold[b] <= hold[b] - 1'b1;
                    end else if (decay[b] == DW'(DECAY_CYCLES - 1)) begin
                        decay[b] <= '0;
                        level[b] <= level[b] - 1'b1;
                    end else begin
                        decay[b] <= decay[b] + 1'b1;
                    end
                end
            end
        end
    end
endmodule
